// File: rtl/alu_pkg.sv
// Shared types for the 8-bit ALU and the execute stage around it.
package alu_pkg;

  localparam int NREGS = 4;

  typedef logic [1:0] reg_idx_t;

  typedef enum logic [1:0] {
    SUB  = 2'd0,
    ADD  = 2'd1,
    NAND = 2'd2,
    MOV  = 2'd3
  } op_t;

endpackage

// File: rtl/alu_exec_if.sv
// Instruction issue handshake and write-back observation bundle for alu_exec.
interface alu_exec_if;

  logic                  in_valid;
  logic                  in_ready;
  alu_pkg::op_t          in_op;
  alu_pkg::reg_idx_t     in_rd;
  alu_pkg::reg_idx_t     in_rs;
  logic [7:0]            in_imm;
  logic                  in_use_imm;

  logic                  wb_valid;
  alu_pkg::reg_idx_t     wb_rd;
  logic [7:0]            wb_data;
  logic                  wb_zero;
  logic                  wb_carry;

  // Issuer / observer side.
  modport master (
    output in_valid, in_op, in_rd, in_rs, in_imm, in_use_imm,
    input  in_ready, wb_valid, wb_rd, wb_data, wb_zero, wb_carry
  );

  // Execute-stage side.
  modport slave (
    input  in_valid, in_op, in_rd, in_rs, in_imm, in_use_imm,
    output in_ready, wb_valid, wb_rd, wb_data, wb_zero, wb_carry
  );

endinterface

// File: rtl/alu.sv
// Combinational 8-bit ALU: SUB (b - a, carry = no-borrow), ADD, NAND.
module alu
  import alu_pkg::*;
(
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  op_t        op,
  output logic [7:0] y,
  output logic       zero,
  output logic       carry
);

  logic [8:0] sum;

  // Select the operation; MOV falls into the default and yields zeros.
  always_comb begin
    sum   = 9'd0;
    y     = 8'd0;
    carry = 1'b0;
    case (op)
      SUB: begin
        sum   = {1'b0, b} - {1'b0, a};
        y     = sum[7:0];
        carry = ~sum[8];
      end
      ADD: begin
        sum   = {1'b0, a} + {1'b0, b};
        y     = sum[7:0];
        carry = sum[8];
      end
      NAND: begin
        y = ~(a & b);
      end
      default: begin
        y = 8'd0;
      end
    endcase
    zero = (y == 8'd0);
  end

endmodule

// File: rtl/alu_exec.sv
// Single-issue execute stage: E register, 4x8 register file, flags and
// a one-cycle write-back observation port around the combinational alu.
module alu_exec
#(
  parameter int NREGS = alu_pkg::NREGS
)
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              hold,
  input  alu_pkg::reg_idx_t dbg_addr,
  output logic [7:0]        dbg_data,
  alu_exec_if.slave         bus
);

  logic              ex_valid_q, ex_valid_d;
  alu_pkg::op_t      ex_op_q, ex_op_d;
  alu_pkg::reg_idx_t ex_rd_q, ex_rd_d;
  alu_pkg::reg_idx_t ex_rs_q, ex_rs_d;
  logic [7:0]        ex_imm_q, ex_imm_d;
  logic              ex_use_imm_q, ex_use_imm_d;

  logic [7:0]        regs_q [NREGS];
  logic [7:0]        regs_d [NREGS];
  logic              zero_q, zero_d;
  logic              carry_q, carry_d;

  logic              wb_valid_q, wb_valid_d;
  alu_pkg::reg_idx_t wb_rd_q, wb_rd_d;
  logic [7:0]        wb_data_q, wb_data_d;

  logic              accept;
  logic              retire;
  logic [7:0]        op_a;
  logic [7:0]        op_b;
  logic [7:0]        alu_y;
  logic              alu_zero;
  logic              alu_carry;
  logic [7:0]        result;

  assign bus.in_ready = ~hold;
  assign accept       = bus.in_valid & ~hold;
  assign retire       = ex_valid_q & ~hold;

  assign op_a   = ex_use_imm_q ? ex_imm_q : regs_q[ex_rs_q];
  assign op_b   = regs_q[ex_rd_q];
  assign result = (ex_op_q == alu_pkg::MOV) ? op_a : alu_y;

  alu u_alu (
    .a     (op_a),
    .b     (op_b),
    .op    (ex_op_q),
    .y     (alu_y),
    .zero  (alu_zero),
    .carry (alu_carry)
  );

  // E register: frozen by hold, otherwise loads whatever is accepted this edge.
  always_comb begin
    ex_valid_d   = ex_valid_q;
    ex_op_d      = ex_op_q;
    ex_rd_d      = ex_rd_q;
    ex_rs_d      = ex_rs_q;
    ex_imm_d     = ex_imm_q;
    ex_use_imm_d = ex_use_imm_q;
    if (!hold) begin
      ex_valid_d = accept;
      if (accept) begin
        ex_op_d      = bus.in_op;
        ex_rd_d      = bus.in_rd;
        ex_rs_d      = bus.in_rs;
        ex_imm_d     = bus.in_imm;
        ex_use_imm_d = bus.in_use_imm;
      end
    end
  end

  // Retirement: write rd, update flags for ALU ops, load the write-back port.
  always_comb begin
    regs_d     = regs_q;
    zero_d     = zero_q;
    carry_d    = carry_q;
    wb_valid_d = retire;
    wb_rd_d    = wb_rd_q;
    wb_data_d  = wb_data_q;
    if (retire) begin
      regs_d[ex_rd_q] = result;
      wb_rd_d         = ex_rd_q;
      wb_data_d       = result;
      if (ex_op_q != alu_pkg::MOV) begin
        zero_d  = alu_zero;
        carry_d = alu_carry;
      end
    end
  end

  // State update; reset discards any in-flight instruction and clears the file.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_valid_q   <= 1'b0;
      ex_op_q      <= alu_pkg::SUB;
      ex_rd_q      <= '0;
      ex_rs_q      <= '0;
      ex_imm_q     <= 8'd0;
      ex_use_imm_q <= 1'b0;
      for (int i = 0; i < NREGS; i++) regs_q[i] <= 8'd0;
      zero_q       <= 1'b0;
      carry_q      <= 1'b0;
      wb_valid_q   <= 1'b0;
      wb_rd_q      <= '0;
      wb_data_q    <= 8'd0;
    end else begin
      ex_valid_q   <= ex_valid_d;
      ex_op_q      <= ex_op_d;
      ex_rd_q      <= ex_rd_d;
      ex_rs_q      <= ex_rs_d;
      ex_imm_q     <= ex_imm_d;
      ex_use_imm_q <= ex_use_imm_d;
      regs_q       <= regs_d;
      zero_q       <= zero_d;
      carry_q      <= carry_d;
      wb_valid_q   <= wb_valid_d;
      wb_rd_q      <= wb_rd_d;
      wb_data_q    <= wb_data_d;
    end
  end

  assign bus.wb_valid = wb_valid_q;
  assign bus.wb_rd    = wb_rd_q;
  assign bus.wb_data  = wb_data_q;
  assign bus.wb_zero  = zero_q;
  assign bus.wb_carry = carry_q;
  assign dbg_data     = regs_q[dbg_addr];

endmodule

// File: tb/tb_alu_exec.sv
// Directed and model-checked random stimulus for the alu_exec execute stage.
module tb_alu_exec;
  import alu_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       hold = 1'b0;
  reg_idx_t   dbg_addr = 2'd0;
  logic [7:0] dbg_data;
  logic       ready_seen;

  int checkCount = 0;
  int passCount  = 0;

  // Reference model state for the random phase.
  logic [7:0] mRegs [4];
  logic       mZero, mCarry;
  logic       mExValid;
  op_t        mOp;
  reg_idx_t   mRd, mRs;
  logic [7:0] mImm;
  logic       mUseImm;
  logic       expWbValid;
  reg_idx_t   expWbRd;
  logic [7:0] expWbData;

  alu_exec_if bus();

  alu_exec dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .hold     (hold),
    .dbg_addr (dbg_addr),
    .dbg_data (dbg_data),
    .bus      (bus)
  );

  // Free-running 10-unit clock.
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed === expected) passCount++;
    else $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, observed, expected);
  endtask

  // Drive one cycle of inputs, capture in_ready mid-cycle, then step past the edge.
  task automatic applyStimulus(input logic v, input op_t op, input reg_idx_t rd, input reg_idx_t rs,
                               input logic [7:0] imm, input logic useImm, input logic h);
    bus.in_valid   = v;
    bus.in_op      = op;
    bus.in_rd      = rd;
    bus.in_rs      = rs;
    bus.in_imm     = imm;
    bus.in_use_imm = useImm;
    hold           = h;
    #1;
    ready_seen = bus.in_ready;
    @(posedge clk);
    #1;
  endtask

  task automatic idleCycle();
    applyStimulus(1'b0, SUB, 2'd0, 2'd0, 8'h00, 1'b0, 1'b0);
  endtask

  task automatic checkReg(input string tag, input reg_idx_t idx, input logic [7:0] expected);
    dbg_addr = idx;
    #1;
    checkOutput(tag, dbg_data, expected);
  endtask

  task automatic checkWb(input string tag, input logic v, input reg_idx_t rd, input logic [7:0] data,
                         input logic z, input logic c);
    checkOutput({tag, "_valid"}, bus.wb_valid, v);
    checkOutput({tag, "_rd"},    bus.wb_rd,    rd);
    checkOutput({tag, "_data"},  bus.wb_data,  data);
    checkOutput({tag, "_zero"},  bus.wb_zero,  z);
    checkOutput({tag, "_carry"}, bus.wb_carry, c);
  endtask

  // Advance the reference model across one edge with the given inputs.
  task automatic modelStep(input logic v, input op_t op, input reg_idx_t rd, input reg_idx_t rs,
                           input logic [7:0] imm, input logic useImm, input logic h);
    logic [7:0] a, b, res;
    logic [8:0] sum;
    expWbValid = 1'b0;
    if (!h) begin
      if (mExValid) begin
        a = mUseImm ? mImm : mRegs[mRs];
        b = mRegs[mRd];
        case (mOp)
          SUB:  begin res = b - a; mCarry = (b >= a); mZero = (res == 8'd0); end
          ADD:  begin sum = a + b; res = sum[7:0]; mCarry = sum[8]; mZero = (res == 8'd0); end
          NAND: begin res = ~(a & b); mCarry = 1'b0; mZero = (res == 8'd0); end
          default: res = a;
        endcase
        mRegs[mRd] = res;
        expWbValid = 1'b1;
        expWbRd    = mRd;
        expWbData  = res;
      end
      mExValid = v;
      if (v) begin
        mOp = op; mRd = rd; mRs = rs; mImm = imm; mUseImm = useImm;
      end
    end
  endtask

  initial begin
    int accepted;
    int cycles;
    logic v, ui, h;
    op_t op;
    reg_idx_t rd, rs;
    logic [7:0] imm;

    bus.in_valid = 1'b0; bus.in_op = SUB; bus.in_rd = 2'd0; bus.in_rs = 2'd0;
    bus.in_imm = 8'h00; bus.in_use_imm = 1'b0;

    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    checkWb("rst", 1'b0, 2'd0, 8'h00, 1'b0, 1'b0);
    checkOutput("rst_in_ready", bus.in_ready, 1'b1);
    checkReg("rst_r3", 2'd3, 8'h00);
    rst_n = 1'b1;

    // Back-to-back MOVs.
    applyStimulus(1'b1, MOV, 2'd0, 2'd0, 8'h05, 1'b1, 1'b0);
    checkOutput("mov_first_nowb", bus.wb_valid, 1'b0);
    applyStimulus(1'b1, MOV, 2'd1, 2'd0, 8'h03, 1'b1, 1'b0);
    checkWb("mov0", 1'b1, 2'd0, 8'h05, 1'b0, 1'b0);
    checkReg("mov0_r0", 2'd0, 8'h05);
    idleCycle();
    checkWb("mov1", 1'b1, 2'd1, 8'h03, 1'b0, 1'b0);
    idleCycle();
    checkWb("mov_idle", 1'b0, 2'd1, 8'h03, 1'b0, 1'b0);

    // ADD with carry followed by dependent SUB with borrow.
    applyStimulus(1'b1, MOV, 2'd0, 2'd0, 8'hF0, 1'b1, 1'b0);
    applyStimulus(1'b1, MOV, 2'd1, 2'd0, 8'h20, 1'b1, 1'b0);
    applyStimulus(1'b1, ADD, 2'd0, 2'd1, 8'h00, 1'b0, 1'b0);
    applyStimulus(1'b1, SUB, 2'd0, 2'd1, 8'h00, 1'b0, 1'b0);
    checkWb("add", 1'b1, 2'd0, 8'h10, 1'b0, 1'b1);
    idleCycle();
    checkWb("sub_dep", 1'b1, 2'd0, 8'hF0, 1'b0, 1'b0);
    checkReg("sub_dep_r0", 2'd0, 8'hF0);

    // SUB to zero, then NAND with immediate.
    applyStimulus(1'b1, MOV, 2'd1, 2'd0, 8'h03, 1'b1, 1'b0);
    applyStimulus(1'b1, SUB, 2'd1, 2'd0, 8'h03, 1'b1, 1'b0);
    applyStimulus(1'b1, NAND, 2'd1, 2'd0, 8'hFF, 1'b1, 1'b0);
    checkWb("sub_zero", 1'b1, 2'd1, 8'h00, 1'b1, 1'b1);
    idleCycle();
    checkWb("nand", 1'b1, 2'd1, 8'hFF, 1'b0, 1'b0);

    // Hold with an instruction in E: flags set to 1/1 first by SUB r1 - 0xFF.
    applyStimulus(1'b1, SUB, 2'd1, 2'd0, 8'hFF, 1'b1, 1'b0);
    applyStimulus(1'b1, ADD, 2'd2, 2'd0, 8'h01, 1'b1, 1'b0);
    checkWb("pre_hold", 1'b1, 2'd1, 8'h00, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, MOV, 2'd3, 2'd0, 8'hAA, 1'b1, 1'b1);
      checkOutput("hold_in_ready", ready_seen, 1'b0);
      checkWb("hold", 1'b0, 2'd1, 8'h00, 1'b1, 1'b1);
      checkReg("hold_r2", 2'd2, 8'h00);
      checkReg("hold_r3", 2'd3, 8'h00);
    end
    applyStimulus(1'b1, MOV, 2'd3, 2'd0, 8'hAA, 1'b1, 1'b0);
    checkOutput("release_in_ready", ready_seen, 1'b1);
    checkWb("release", 1'b1, 2'd2, 8'h01, 1'b0, 1'b0);
    idleCycle();
    checkWb("release_next", 1'b1, 2'd3, 8'hAA, 1'b0, 1'b0);

    // Reset between accept and retire.
    applyStimulus(1'b1, ADD, 2'd2, 2'd0, 8'h7F, 1'b1, 1'b0);
    bus.in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    checkWb("midrst", 1'b0, 2'd0, 8'h00, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    checkOutput("midrst_edge_valid", bus.wb_valid, 1'b0);
    rst_n = 1'b1;
    idleCycle();
    checkWb("after_rst", 1'b0, 2'd0, 8'h00, 1'b0, 1'b0);
    checkReg("after_rst_r2", 2'd2, 8'h00);

    // Random stream against the reference model; DUT is freshly reset.
    for (int i = 0; i < 4; i++) mRegs[i] = 8'h00;
    mZero = 1'b0; mCarry = 1'b0; mExValid = 1'b0;
    mOp = SUB; mRd = 2'd0; mRs = 2'd0; mImm = 8'h00; mUseImm = 1'b0;
    expWbRd = 2'd0; expWbData = 8'h00; expWbValid = 1'b0;
    accepted = 0;
    cycles = 0;
    while (accepted < 1000 && cycles < 5000) begin
      v   = ($urandom_range(0, 9) < 8);
      h   = ($urandom_range(0, 3) == 0);
      op  = op_t'($urandom_range(0, 3));
      rd  = reg_idx_t'($urandom_range(0, 3));
      rs  = reg_idx_t'($urandom_range(0, 3));
      imm = 8'($urandom_range(0, 255));
      ui  = $urandom_range(0, 1) == 1;
      if (v && !h) accepted++;
      modelStep(v, op, rd, rs, imm, ui, h);
      applyStimulus(v, op, rd, rs, imm, ui, h);
      checkWb("rnd", expWbValid, expWbRd, expWbData, mZero, mCarry);
      cycles++;
    end
    checkOutput("rnd_cycle_budget", accepted >= 1000, 1'b1);
    modelStep(1'b0, SUB, 2'd0, 2'd0, 8'h00, 1'b0, 1'b0);
    idleCycle();
    checkWb("rnd_drain", expWbValid, expWbRd, expWbData, mZero, mCarry);
    for (int i = 0; i < 4; i++) checkReg("rnd_final_reg", reg_idx_t'(i), mRegs[i]);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/alu_exec.md
# alu_exec

Single-issue execute stage wrapped around the 8-bit `alu`. It accepts one instruction per cycle over a valid/ready handshake and holds a 4×8 register file plus registered zero/carry flags. It drives `alu` with operands read from that file or an immediate, then writes the result back. It also presents every retired result on a one-cycle write-back observation port for the downstream sequencer and the bench.

## Interface
Parameters:
- `NREGS`, 4: register-file depth. Fixed at 4 so that `rd`/`rs` are 2 bits.

Ports:
- `clk`  in  1  sole clock, rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `in_valid`  in  1  instruction present
- `in_ready`  out  1  stage can accept; equals `~hold`
- `in_op`  in  2  opcode from `alu_pkg::op_t`: SUB=0, ADD=1, NAND=2, MOV=3
- `in_rd`  in  2  destination register; also ALU operand `b`
- `in_rs`  in  2  source register; ALU operand `a` when `in_use_imm`=0
- `in_imm`  in  8  immediate; ALU operand `a` when `in_use_imm`=1
- `in_use_imm`  in  1  selects the immediate as operand `a`
- `hold`  in  1  freeze request from downstream
- `wb_valid`  out  1  one-cycle pulse per retired instruction
- `wb_rd`  out  2  register written by the retired instruction
- `wb_data`  out  8  value written
- `wb_zero`, `wb_carry`  out  1 each  flag register contents after retirement
- `dbg_addr`  in  2  debug read address
- `dbg_data`  out  8  combinational `regs[dbg_addr]`

## Operation
- Handshake: an instruction is accepted on a rising edge with `in_valid && in_ready`. `in_ready` is combinational `~hold` and does not depend on `in_valid`.
- E register: holds the accepted instruction (`ex_valid`, op, rd, rs, imm, use_imm).
- Execute, while `ex_valid` is high and `hold` is low:
  - `a` = use_imm ? imm : `regs[rs]`; `b` = `regs[rd]`.
  - SUB: result = `b - a` (rd − rs), 8-bit wrap; carry = no-borrow, so carry=1 iff b ≥ a.
  - ADD: result = `(a + b) mod 256`; carry = bit 8 of the 9-bit sum.
  - NAND: result = `~(a & b)`; carry = 0.
  - MOV: result = `a`. Bypasses the ALU. Flags are unchanged.
- Zero flag = (result == 0) for SUB, ADD and NAND.
- Retire edge: `regs[rd]` ← result. For SUB/ADD/NAND, flags ← ALU zero and carry. The W outputs load and `wb_valid` ← 1.
- Any edge that does not retire: `wb_valid` ← 0. `wb_rd` and `wb_data` hold their last values.
- Hazards: none. An instruction reads the file in the cycle after the previous instruction's write edge, so back-to-back dependent instructions see updated values without forwarding.
- `hold`=1 freezes the E register and suppresses register-file and flag writes. The held instruction retires on the first edge with `hold`=0; on that same edge a new instruction may be accepted.
- Reset (asserted at any time, including mid-instruction):
  - `ex_valid`=0 and `wb_valid`=0, so an in-flight instruction is discarded.
  - All regs, `wb_rd`, `wb_data`, `wb_zero` and `wb_carry` are 0.
  - `in_ready` follows `~hold` during reset, but acceptance only occurs on an edge with `rst_n`=1.

## Timing
- Accept at edge T; execute during cycle T..T+1; retire at edge T+1.
- `wb_valid` is high during cycle T+1..T+2.
- `dbg_data` shows the new value from T+1.
- Throughput: 1 instruction per cycle when `hold`=0.
- Latency from accept to register visible: 1 edge.
- The ALU path is combinational within the execute cycle. No output is combinational from `in_*` except `in_ready` (from `hold`).

## Structure
- `alu_pkg`: `op_t` enum {SUB, ADD, NAND, MOV}; constant `NREGS`=4; typedef `reg_idx_t` = logic[1:0]. `alu` is switched to this package. MOV uses the ALU's default encoding and must not be routed through it.
- Instantiates the existing `alu` as its single sub-module. The register file, E register and W register are inline.

## Test plan
- Reset, then MOV r0←imm 0x05 and MOV r1←imm 0x03 back-to-back → `wb_valid` on consecutive cycles; `wb_data` 0x05 then 0x03; flags stay 0/0.
- With r0=0xF0, r1=0x20, ADD rd=r0 rs=r1 → r0=0x10, `wb_carry`=1, `wb_zero`=0. A dependent SUB rd=r0 rs=r1 in the next cycle → 0x10−0x20 = 0xF0, carry=0.
- SUB rd=r1 imm 0x03 with r1=0x03 → r1=0x00, zero=1, carry=1. A following NAND rd=r1 imm 0xFF → 0xFF, zero=0, carry=0.
- `hold`=1 for 3 cycles with an instruction in E → `in_ready`=0, no `wb_valid`, regs and flags unchanged. Release → retires on the next edge while a new instruction is accepted the same edge.
- Pulse `rst_n` low between accept and retire of ADD r2←imm 0x7F → no `wb_valid`; r2=0 and flags=0 afterwards.
- Random stream of 1000 instructions with random `hold` against a reference model → regs, flags and `wb_*` match at every retire.
